pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline control unit for the MIPS core; replaces the fixed 6-bit combinational stall controller.
//  Merges per-stage stall and flush requests into stall/flush vectors for all pipeline registers.
//  Redirects pc_reg on a flush and runs a stall watchdog.
//  Sits at CPU top level beside pc_reg, if_id, id_ex, ex_mem and mem_wb.
// PARAMETERS
//  NUM_STAGES    6   pipeline stages; index 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb
//  PC_W          32  width of redirect PC
//  WDOG_W        8   watchdog counter width
//  FLUSH_CYCLES  1   cycles flush_o is held (>=1)
// PORTS
//  clk             in   1                 system clock; all state on rising edge
//  rst             in   1                 asynchronous, active-low reset
//  stallreq_i      in   NUM_STAGES        bit k = stage k requests stall
//  flushreq_i      in   NUM_STAGES        bit k = stage k requests flush/redirect
//  flush_pc_i      in   NUM_STAGES*PC_W   redirect target of stage k at [k*PC_W +: PC_W]
//  wdog_limit_i    in   WDOG_W            stall-cycle limit; 0 disables watchdog
//  stall_o         out  NUM_STAGES        1 = hold pipeline register of stage k
//  flush_o         out  NUM_STAGES        1 = load bubble into stage k
//  new_pc_o        out  PC_W              redirect PC to pc_reg
//  new_pc_valid_o  out  1                 1-cycle pulse: pc_reg loads new_pc_o
//  wdog_trip_o     out  1                 1-cycle pulse: stall limit reached
//  stall_cnt_o     out  WDOG_W            consecutive stalled cycles
//  state_o         out  2                 00 RUN, 01 STALL, 10 FLUSH, 11 STEP
// BEHAVIOUR
//  - Reset (rst=0, async): stall_o=0, flush_o=0, new_pc_o=0, new_pc_valid_o=0, wdog_trip_o=0, stall_cnt_o=0,
//    state=RUN. Outputs are held at these values while rst=0.
//  - Stall (combinational, 0-cycle latency): k = highest set bit of stallreq_i; stall_o[k:0]=1, remaining bits 0.
//    No request gives stall_o=0. stall_o is forced to 0 in FLUSH.
//  - State: RUN->STALL when stall_o!=0 at the clock edge; STALL->RUN when stallreq_i=0.
//  - Flush (registered, 1-cycle latency): if flushreq_i!=0 in RUN/STALL at edge n, j = highest set bit (oldest
//    instruction wins). From cycle n+1: state=FLUSH, flush_o[j:0]=1, new_pc_o=flush_pc_i[j], new_pc_valid_o=1
//    for the first FLUSH cycle only. flush_o is held FLUSH_CYCLES cycles, then state returns to RUN.
//  - Flush beats stall: a flushreq with stallreq in the same cycle takes the flush path; stall_o=0 during FLUSH.
//  - In FLUSH: a flushreq bit > j restarts FLUSH with the new j and PC (count reloads, new pulse).
//    Bits <= j and all stallreq bits are ignored.
//  - Watchdog: stall_cnt_o +1 each cycle stall_o!=0, saturating at 2^WDOG_W-1. Cleared to 0 on any cycle with
//    stall_o=0. wdog_trip_o pulses the cycle after the counter reaches wdog_limit_i (limit!=0), once per stall
//    episode. No pipeline action on a trip.
//  - Reset mid-FLUSH or mid-stall aborts immediately; no pending redirect survives reset.
// CONFIGURATION
//  PIPE_CTRL_STEP_EN defined: adds ports step_mode_i (in 1) and step_i (in 1).
//   - step_mode_i=1 with no flush pending: state=STEP, stall_o=all ones.
//   - Each rising edge of step_i gives exactly one cycle of normal stall_o (from stallreq_i).
//   - Flush still has priority over STEP; stall_cnt_o does not count STEP hold cycles.
//   - step_mode_i=0 returns to RUN.
//  PIPE_CTRL_STEP_EN undefined: ports absent; state 11 never occurs.
// TESTING (NUM_STAGES=6, PC_W=32, WDOG_W=8, FLUSH_CYCLES=1)
//  1 stallreq_i=6'b001000 -> stall_o=6'b001111 same cycle; state_o=01 next cycle; stallreq 0 -> RUN, stall_cnt 0.
//  2 flushreq_i=6'b010000, flush_pc[4]=32'hBFC00380, 1 cycle -> next cycle: flush_o=6'b011111,
//    new_pc_o=BFC00380, new_pc_valid_o=1, stall_o=0. Cycle after: RUN, flush_o=0.
//  3 flushreq_i=6'b010100 plus stallreq_i=6'b100000 same cycle -> stage 4 target wins; flush_o=6'b011111;
//    stall ignored during FLUSH.
//  4 wdog_limit_i=5, stallreq_i=6'b000100 held 300 cycles -> stall_cnt 1..5, one trip pulse, saturates 255.
//    Repeat with limit=0 -> no trip.
//  5 rst low during FLUSH_CYCLES=3 flush, 2nd cycle -> all outputs 0 immediately; RUN on release,
//    no new_pc_valid_o.
//  6 (STEP_EN) step_mode_i=1 -> stall_o=6'b111111; one step_i pulse -> one cycle stall_o=0; flushreq still redirects.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for the MIPS core.
// Merges per-stage stall and flush requests into per-register hold/bubble
// vectors, redirects pc_reg on a flush and runs a stall-length watchdog.
// Optional single-step support is compiled in with PIPE_CTRL_STEP_EN.
module pipe_ctrl #(
   parameter int NUM_STAGES   = 6,
   parameter int PC_W         = 32,
   parameter int WDOG_W       = 8,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_STAGES-1:0]      stallreq_i,
   input  logic [NUM_STAGES-1:0]      flushreq_i,
   input  logic [NUM_STAGES*PC_W-1:0] flush_pc_i,
   input  logic [WDOG_W-1:0]          wdog_limit_i,
`ifdef PIPE_CTRL_STEP_EN
   input  logic                       step_mode_i,
   input  logic                       step_i,
`endif
   output logic [NUM_STAGES-1:0]      stall_o,
   output logic [NUM_STAGES-1:0]      flush_o,
   output logic [PC_W-1:0]            new_pc_o,
   output logic                       new_pc_valid_o,
   output logic                       wdog_trip_o,
   output logic [WDOG_W-1:0]          stall_cnt_o,
   output logic [1:0]                 state_o
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]   FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [WDOG_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10,
      ST_STEP  = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_STAGES-1:0] flush_q, flush_d;
   logic [PC_W-1:0]       new_pc_q, new_pc_d;
   logic                  valid_q, valid_d;
   logic [FC_W-1:0]       fcnt_q, fcnt_d;
   logic [WDOG_W-1:0]     cnt_q, cnt_d;
   logic                  trip_q, trip_d;
   logic                  tripped_q, tripped_d;

   logic [NUM_STAGES-1:0] stall_therm;
   logic [NUM_STAGES-1:0] flush_therm;
   logic [NUM_STAGES-1:0] stall_c;
   logic [PC_W-1:0]       flush_pc_sel;
   logic                  step_hold;
   logic                  step_pulse;

   // Thermometer masks: bit k is set when any request at stage k or older
   // is present, i.e. bits [highest:0] of the request vector.
   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_therm
         assign stall_therm[gi] = |stallreq_i[NUM_STAGES-1:gi];
         assign flush_therm[gi] = |flushreq_i[NUM_STAGES-1:gi];
      end
   endgenerate

   // Redirect target of the oldest (highest-index) flushing stage.
   always_comb begin
      flush_pc_sel = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (flushreq_i[k]) flush_pc_sel = flush_pc_i[k*PC_W +: PC_W];
      end
   end

`ifdef PIPE_CTRL_STEP_EN
   logic step_prev_q;

   // Remember last step_i level so a rising edge releases exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) step_prev_q <= 1'b0;
      else      step_prev_q <= step_i;
   end

   assign step_pulse = step_i & ~step_prev_q;
   assign step_hold  = (state_q == ST_STEP) && !step_pulse;
`else
   assign step_pulse = 1'b0;
   assign step_hold  = 1'b0;
`endif

   // Next-state, flush/redirect and combinational stall vector.
   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      new_pc_d = new_pc_q;
      valid_d  = 1'b0;
      fcnt_d   = fcnt_q;
      stall_c  = stall_therm;
      case (state_q)
         ST_FLUSH: begin
            // Pipeline is being emptied: holding anything would be pointless.
            stall_c = '0;
            if (|(flushreq_i & ~flush_q)) begin
               // An older stage than the current flush point redirects: restart.
               flush_d  = flush_therm;
               new_pc_d = flush_pc_sel;
               valid_d  = 1'b1;
               fcnt_d   = FC_LOAD;
            end else if (fcnt_q == '0) begin
               state_d = ST_RUN;
               flush_d = '0;
            end else begin
               fcnt_d = fcnt_q - 1'b1;
            end
         end
`ifdef PIPE_CTRL_STEP_EN
         ST_STEP: begin
            if (!step_pulse) stall_c = '1;
            if (|flushreq_i) begin
               state_d  = ST_FLUSH;
               flush_d  = flush_therm;
               new_pc_d = flush_pc_sel;
               valid_d  = 1'b1;
               fcnt_d   = FC_LOAD;
            end else if (!step_mode_i) begin
               state_d = ST_RUN;
            end
         end
`endif
         default: begin
            // RUN / STALL: flush has priority over stall.
            if (|flushreq_i) begin
               state_d  = ST_FLUSH;
               flush_d  = flush_therm;
               new_pc_d = flush_pc_sel;
               valid_d  = 1'b1;
               fcnt_d   = FC_LOAD;
            end
`ifdef PIPE_CTRL_STEP_EN
            else if (step_mode_i) begin
               state_d = ST_STEP;
            end
`endif
            else if (|stall_therm) begin
               state_d = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // Watchdog: count consecutive stalled cycles, pulse once per episode.
   always_comb begin
      cnt_d     = cnt_q;
      trip_d    = 1'b0;
      tripped_d = tripped_q;
      if (wdog_limit_i != '0 && cnt_q == wdog_limit_i && !tripped_q) begin
         trip_d    = 1'b1;
         tripped_d = 1'b1;
      end
      if (stall_c == '0) begin
         cnt_d     = '0;
         tripped_d = 1'b0;
      end else if (!step_hold && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and registered outputs; reset aborts any flush or stall episode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         flush_q   <= '0;
         new_pc_q  <= '0;
         valid_q   <= 1'b0;
         fcnt_q    <= '0;
         cnt_q     <= '0;
         trip_q    <= 1'b0;
         tripped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         new_pc_q  <= new_pc_d;
         valid_q   <= valid_d;
         fcnt_q    <= fcnt_d;
         cnt_q     <= cnt_d;
         trip_q    <= trip_d;
         tripped_q <= tripped_d;
      end
   end

   assign stall_o        = rst ? stall_c : '0;
   assign flush_o        = flush_q;
   assign new_pc_o       = new_pc_q;
   assign new_pc_valid_o = valid_q;
   assign wdog_trip_o    = trip_q;
   assign stall_cnt_o    = cnt_q;
   assign state_o        = state_q;

endmodule
